// File: rtl/bcd_scan_mux_if.sv
// Digit-scan bus between the controller and the bcd_scan_mux display driver.
interface bcd_scan_mux_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  blank_lz;
    logic [3:0]            digit_out;
    logic [DIGITS-1:0]     sel_n;
    logic                  upd_done;

    modport master (
        output en, load, bcd_in, blank_lz,
        input  digit_out, sel_n, upd_done
    );

    modport slave (
        input  en, load, bcd_in, blank_lz,
        output digit_out, sel_n, upd_done
    );
endinterface

// File: rtl/bcd_scan_mux.sv
// Multi-digit BCD scan multiplexer: drives one digit at a time onto a 4-bit
// bus with a one-cold select, applying newly loaded values only at frame
// boundaries so a sweep never mixes old and new digits.
module bcd_scan_mux #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst,
    bcd_scan_mux_if.slave  bus
);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_reg_q, pend_reg_d;
    logic                  pend_q, pend_d;
    logic [3:0]            digit_q, digit_d;
    logic [DIGITS-1:0]     sel_n_q, sel_n_d;
    logic                  upd_q, upd_d;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  upper_zero;
    logic [3:0]            code;

    // Display code for the currently indexed digit (invalid and leading-zero blanking)
    always_comb begin
        nib        = disp_q[{idx_q, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((i >= 32'(idx_q)) && (disp_q[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        if (nib > 4'd9) begin
            code = 4'hF;
        end else if (bus.blank_lz && (idx_q != '0) && upper_zero) begin
            code = 4'hF;
        end else begin
            code = nib;
        end
    end

    // Next-state: prescaler, digit index, frame transfer, load staging, outputs
    always_comb begin
        presc_d    = presc_q;
        idx_d      = idx_q;
        disp_d     = disp_q;
        pend_reg_d = pend_reg_q;
        pend_d     = pend_q;
        digit_d    = 4'hF;
        sel_n_d    = '1;
        upd_d      = 1'b0;

        tick = bus.en && (presc_q == PRESC_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        if (bus.en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                idx_d = wrap ? '0 : idx_q + 1'b1;
            end
            digit_d = code;
            sel_n_d = ~(DIGITS'(1) << idx_q);
        end

        // Transfer consumes the old pending value before a coincident load
        // refills it, so that load survives to the next frame boundary.
        if (wrap && pend_q) begin
            disp_d = pend_reg_q;
            pend_d = 1'b0;
            upd_d  = 1'b1;
        end
        if (bus.load) begin
            pend_reg_d = bus.bcd_in;
            pend_d     = 1'b1;
        end
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            pend_reg_q <= '0;
            pend_q     <= 1'b0;
            digit_q    <= 4'hF;
            sel_n_q    <= '1;
            upd_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_reg_q <= pend_reg_d;
            pend_q     <= pend_d;
            digit_q    <= digit_d;
            sel_n_q    <= sel_n_d;
            upd_q      <= upd_d;
        end
    end

    assign bus.digit_out = digit_q;
    assign bus.sel_n     = sel_n_q;
    assign bus.upd_done  = upd_q;
endmodule

// File: tb/tb_bcd_scan_mux.sv
// Scoreboard bench for bcd_scan_mux: a frame-position reference model pushes
// the expected registered outputs each edge; a monitor pops and compares.
module tb_bcd_scan_mux;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned FRAME    = DIGITS * SCAN_DIV;

    typedef struct packed {
        logic [3:0]        d;
        logic [DIGITS-1:0] s;
        logic              u;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    exp_t exp_q[$];

    // model state
    int          pos      = 0;
    logic [15:0] m_disp   = '0;
    logic [15:0] m_pval   = '0;
    bit          m_pend   = 1'b0;

    bcd_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    bcd_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_digit(input logic [15:0] v, input int idx, input bit blz);
        logic [15:0] upper;
        logic [3:0]  n;
        upper = v >> (4 * idx);
        n     = upper[3:0];
        if (n > 4'd9)                            return 4'hF;
        if (blz && idx != 0 && upper == 16'd0)   return 4'hF;
        return n;
    endfunction

    // Reference model: frame position counts enabled cycles modulo one frame
    always @(posedge clk) begin
        exp_t e;
        int   idx;
        if (rst) begin
            e = '{d: 4'hF, s: '1, u: 1'b0};
            pos = 0; m_disp = '0; m_pval = '0; m_pend = 1'b0;
        end else begin
            e = '{d: 4'hF, s: '1, u: 1'b0};
            if (bus.en) begin
                idx = pos / SCAN_DIV;
                e.d = ref_digit(m_disp, idx, bus.blank_lz);
                e.s = ~(DIGITS'(1) << idx);
                if (pos == FRAME - 1 && m_pend) begin
                    e.u    = 1'b1;
                    m_disp = m_pval;
                    m_pend = 1'b0;
                end
                pos = (pos + 1) % FRAME;
            end
            if (bus.load) begin
                m_pval = bus.bcd_in;
                m_pend = 1'b1;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: compare registered outputs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.digit_out !== e.d || bus.sel_n !== e.s || bus.upd_done !== e.u) begin
                failures++;
                $display("FAIL outputs t=%0t actual digit=%h sel_n=%b upd=%b required digit=%h sel_n=%b upd=%b",
                         $time, bus.digit_out, bus.sel_n, bus.upd_done, e.d, e.s, e.u);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.bcd_in = v;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    // wait until the next edge is the one where the frame position is p
    task automatic wait_pos(input int p);
        int n = 0;
        while (!(bus.en && pos == p) && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(bus.en && pos == p)) begin
            failures++;
            $display("FAIL wait_pos actual pos=%0d required pos=%0d", pos, p);
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.load = 1'b0; bus.bcd_in = '0; bus.blank_lz = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // basic scan of 1234
        bus.en = 1'b1;
        do_load(16'h1234);
        idle(48);
        // leading-zero blanking on/off
        bus.blank_lz = 1'b1;
        do_load(16'h0045);
        idle(36);
        bus.blank_lz = 1'b0;
        idle(32);
        bus.blank_lz = 1'b1;
        do_load(16'h0000);
        idle(36);
        do_load(16'h12A4);
        idle(36);
        // last load wins within a frame
        wait_pos(2);
        do_load(16'h1111);
        idle(5);
        do_load(16'h2222);
        idle(36);
        // load coincident with the frame wrap
        wait_pos(4);
        do_load(16'h4444);
        wait_pos(FRAME - 1);
        do_load(16'h5555);
        idle(40);
        // freeze mid-frame, load while frozen, resume
        wait_pos(6);
        bus.en = 1'b0;
        idle(3);
        do_load(16'h6789);
        idle(4);
        bus.en = 1'b1;
        idle(40);
        // reset mid-scan with a pending value
        wait_pos(9);
        do_load(16'h9876);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(40);

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            bus.en       = ($urandom_range(0, 9) != 0);
            bus.blank_lz = $urandom_range(0, 1);
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.bcd_in   = 16'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                // mostly valid BCD digits, sometimes with leading zeros
                for (int k = 0; k < 4; k++) bus.bcd_in[4*k +: 4] = 4'($urandom_range(0, 9));
                if ($urandom_range(0, 1) != 0) bus.bcd_in[15:8] = 8'h00;
            end
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0; bus.load = 1'b0; bus.en = 1'b1;
        idle(3);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Upstream stage for the 7-segment BCD decoder.
- Holds a multi-digit BCD value and time-multiplexes it onto a single 4-bit digit bus, with a one-cold digit-select bus for a common-anode display.
- New values are staged and applied only at frame boundaries, so a digit sweep never mixes old and new digits.
- Blanked or invalid digits are driven as 4'hF; the decoder maps every code above 9 to all-segments-off.

Parameters:
- DIGITS, 4, number of display digits (2..8).
- SCAN_DIV, 50000, clock cycles each digit stays selected (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  scan enable; low blanks the display and freezes the scan.
- load  in  1  one-cycle strobe; captures bcd_in into the pending register.
- bcd_in  in  4*DIGITS  BCD value; nibble 0 (bits 3:0) is the least significant digit.
- blank_lz  in  1  leading-zero blanking enable.
- digit_out  out  4  BCD code to the decoder; 4'hF means blank.
- sel_n  out  DIGITS  digit select, active-low, at most one bit low.
- upd_done  out  1  one-cycle pulse when a pending value becomes the displayed value.

Behaviour:
- Internal state:
  - presc: 0..SCAN_DIV-1.
  - idx: 0..DIGITS-1.
  - disp_reg and pend_reg: 4*DIGITS bits each.
  - pend: 1-bit flag.
- Reset (rst=1 at a clock edge, overrides all other inputs, including mid-frame and mid-load):
  - presc=0, idx=0, disp_reg=0, pend_reg=0, pend=0.
  - Outputs: digit_out=4'hF, sel_n=all ones, upd_done=0.
- Scan counter, while en=1:
  - presc increments each cycle.
  - When presc==SCAN_DIV-1: presc wraps to 0 and a tick occurs. On a tick, idx advances; DIGITS-1 wraps to 0.
- Scan freeze, while en=0:
  - presc and idx hold.
  - Registered outputs go to digit_out=4'hF, sel_n=all ones.
- Output timing:
  - All outputs are registered.
  - When en=1, at each edge digit_out and sel_n are loaded from the current idx and disp_reg. Outputs therefore lag idx by one cycle.
  - sel_n[idx]=0; all other bits are 1.
  - After en rises, digit 0 appears one cycle later.
- Digit value, from nibble n = disp_reg[4*idx+3:4*idx]:
  - If n>9: output 4'hF.
  - Else if blank_lz=1, idx!=0, and nibbles DIGITS-1 down to idx are all zero: output 4'hF.
  - Else: output n.
  - Digit 0 is never blanked by leading-zero blanking; value 0 displays as a single "0".
- Load:
  - When load=1: pend_reg<=bcd_in, pend<=1.
  - If pend was already set, the new value overwrites pend_reg (last load wins).
  - Load is accepted even when en=0.
- Frame transfer occurs on a tick where idx wraps DIGITS-1 -> 0 while pend=1:
  - disp_reg<=pend_reg, pend<=0, upd_done=1 for exactly the next cycle.
  - The new value is first seen on digit 0 of the new frame.
- Load and transfer in the same cycle:
  - disp_reg takes the old pend_reg and upd_done pulses.
  - pend_reg takes bcd_in and pend stays 1; it transfers at the next frame boundary.
- With en=0, no ticks occur, so no transfer occurs; pend stays set until scanning resumes.
- Invalid BCD nibbles are stored unmodified. Only their displayed code is forced to 4'hF.

Test Plan (SCAN_DIV=4, DIGITS=4):
- Reset, then en=1, load bcd_in=16'h1234, and run 3 frames:
  - upd_done pulses once, at the first wrap.
  - Afterwards, each 4-cycle slot shows digit_out=4,3,2,1 with sel_n=1110,1101,1011,0111.
  - The pattern repeats every 16 cycles.
- Load 16'h0045 with blank_lz=1 -> digits 3 and 2 output F; digits 1 and 0 output 4 and 5.
- Repeat with blank_lz=0 -> digits output 0,0,4,5.
- Load 16'h0000 with blank_lz=1 -> only digit 0 outputs 0; the others output F.
- Load 16'h12A4 -> digit 1 outputs F; digits 0, 2 and 3 output 4, 2 and 1.
- Frame-boundary staging:
  - Load 16'h1111, then 16'h2222 mid-frame -> only 2222 is displayed and upd_done pulses once.
  - Assert load on the exact wrap cycle -> the old pending value is applied, and the new value is applied one frame later.
- en and reset interaction:
  - Drop en mid-frame -> the next cycle has sel_n=1111 and digit_out=F.
  - Raise en -> the scan resumes from the frozen idx/presc.
  - Assert rst during scan -> the next cycle has sel_n=1111, digit_out=F, pend cleared, and no upd_done.
